// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one external combinational 8x8 multiplier between N requesters.
// Operands are registered and held for SETTLE cycles before the product is captured.
module mul_share_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned IDW    = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   a_in,
  input  logic [8*N-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_w,
  output logic [15:0]      res,
  output logic [IDW-1:0]   res_id,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int unsigned CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNTW-1:0] CntLoad = CNTW'(SETTLE - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  win_q, win_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [N-1:0]    gnt_d;
  logic [7:0]      mul_a_d, mul_b_d;
  logic [15:0]     res_d;
  logic [IDW-1:0]  res_id_d;
  logic            res_valid_d;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [7:0]      sel_a, sel_b;

  // Two-pass scan: indices at or above ptr first, then the wrapped-around lower indices.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!pick_found && req[i] && (i >= int'(ptr_q))) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!pick_found && req[i] && (i < int'(ptr_q))) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(i);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == IDW'(i)) begin
        sel_a = a_in[8*i +: 8];
        sel_b = b_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    mul_a_d     = mul_a;
    mul_b_d     = mul_b;
    res_d       = res;
    res_id_d    = res_id;
    res_valid_d = res_valid;

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          mul_a_d = sel_a;
          mul_b_d = sel_b;
          for (int i = 0; i < N; i++) begin
            gnt_d[i] = (pick_idx == IDW'(i));
          end
          win_d   = pick_idx;
          ptr_d   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        // Operands stay put while the ripple array settles.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          res_d       = mul_w;
          res_id_d    = win_q;
          res_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      res       <= '0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      mul_a     <= mul_a_d;
      mul_b     <= mul_b_d;
      res       <= res_d;
      res_id    <= res_id_d;
      res_valid <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: a SETTLE=2 instance and a SETTLE=1 instance,
// each feeding a combinational multiplier model; monitors pop expected grants and results.
module tb_mul_share_arbiter;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] a;
    logic [7:0] b;
  } gexp_t;

  typedef struct packed {
    logic [15:0] r;
    logic [1:0]  id;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req1;
  logic [31:0] a_in, b_in, a1, b1;
  logic        ready, ready1;
  logic [3:0]  gnt, gnt1;
  logic [7:0]  mul_a, mul_b, mul_a1, mul_b1;
  logic [15:0] mul_w, mul_w1, res, res1;
  logic [1:0]  res_id, res_id1;
  logic        res_valid, res_valid1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  gexp_t gq[$], g1q[$];
  rexp_t rq[$], r1q[$];
  int    gnt_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mul_w  = 16'(mul_a) * 16'(mul_b);
  assign mul_w1 = 16'(mul_a1) * 16'(mul_b1);

  mul_share_arbiter #(.N(4), .IDW(2), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .mul_a(mul_a), .mul_b(mul_b), .mul_w(mul_w), .res(res), .res_id(res_id),
    .res_valid(res_valid), .res_ready(ready)
  );

  mul_share_arbiter #(.N(4), .IDW(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .a_in(a1), .b_in(b1), .gnt(gnt1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_w(mul_w1), .res(res1), .res_id(res_id1),
    .res_valid(res_valid1), .res_ready(ready1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requesters drop req right after seeing their grant.
  task automatic tick();
    @(posedge clk);
    #1;
    req  = req & ~gnt;
    req1 = req1 & ~gnt1;
  endtask

  task automatic exp_op(input logic [3:0] g, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] r, input logic [1:0] id);
    gq.push_back({g, a, b});
    rq.push_back({r, id});
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60; k++) begin
      if (gq.size() + rq.size() + g1q.size() + r1q.size() == 0) break;
      tick();
    end
    chk({"drain_", name}, gq.size() + rq.size() + g1q.size() + r1q.size(), 0);
    tick();
    tick();
  endtask

  // Monitor for the SETTLE=2 instance.
  initial begin
    gexp_t ge;
    rexp_t re;
    logic [3:0] prev_gnt;
    logic prev_valid;
    int last_gnt_cyc;
    prev_gnt = '0;
    prev_valid = 1'b0;
    last_gnt_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_gnt = '0;
        prev_valid = 1'b0;
      end else begin
        if (gnt != '0) begin
          if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
          else begin
            ge = gq.pop_front();
            chk("gnt", gnt, ge.g);
            chk("mul_a", mul_a, ge.a);
            chk("mul_b", mul_b, ge.b);
          end
          chk("gnt_pulse", prev_gnt, 0);
          chk("gnt_while_valid", res_valid, 0);
          last_gnt_cyc = cyc;
          gnt_log.push_back(cyc);
        end
        if (res_valid && !prev_valid) chk("latency", cyc - last_gnt_cyc, 2);
        if (res_valid && ready) begin
          if (rq.size() == 0) chk("res_unexpected", res_valid, 0);
          else begin
            re = rq.pop_front();
            chk("res", res, re.r);
            chk("res_id", res_id, re.id);
          end
        end
        prev_gnt = gnt;
        prev_valid = res_valid;
      end
    end
  end

  // Monitor for the SETTLE=1 instance.
  initial begin
    gexp_t ge;
    rexp_t re;
    logic prev_valid;
    int last_gnt_cyc;
    prev_valid = 1'b0;
    last_gnt_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (gnt1 != '0) begin
          if (g1q.size() == 0) chk("s1_gnt_unexpected", gnt1, 0);
          else begin
            ge = g1q.pop_front();
            chk("s1_gnt", gnt1, ge.g);
            chk("s1_mul_a", mul_a1, ge.a);
            chk("s1_mul_b", mul_b1, ge.b);
          end
          last_gnt_cyc = cyc;
        end
        if (res_valid1 && !prev_valid) chk("s1_latency", cyc - last_gnt_cyc, 1);
        if (res_valid1 && ready1) begin
          if (r1q.size() == 0) chk("s1_res_unexpected", res_valid1, 0);
          else begin
            re = r1q.pop_front();
            chk("s1_res", res1, re.r);
            chk("s1_res_id", res_id1, re.id);
          end
        end
        prev_valid = res_valid1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    req1 = '0;
    a_in = '0;
    b_in = '0;
    a1 = '0;
    b1 = '0;
    ready = 1'b0;
    ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_res", res, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_s1_valid", res_valid1, 0);
    rst = 1'b0;

    // Single request from requester 1.
    ready = 1'b1;
    a_in[15:8] = 8'h0F;
    b_in[15:8] = 8'h11;
    exp_op(4'b0010, 8'h0F, 8'h11, 16'h00FF, 2'd1);
    req = 4'b0010;
    drain("t1");

    // All four requesting from reset: order 0..3, spacing SETTLE+2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gnt_log.delete();
    a_in = 32'hFFFF_FFFF;
    b_in = 32'hFFFF_FFFF;
    exp_op(4'b0001, 8'hFF, 8'hFF, 16'hFE01, 2'd0);
    exp_op(4'b0010, 8'hFF, 8'hFF, 16'hFE01, 2'd1);
    exp_op(4'b0100, 8'hFF, 8'hFF, 16'hFE01, 2'd2);
    exp_op(4'b1000, 8'hFF, 8'hFF, 16'hFE01, 2'd3);
    req = 4'b1111;
    drain("t2");
    chk("t2_grant_count", gnt_log.size(), 4);
    for (int i = 1; i < 4; i++) begin
      if (i < gnt_log.size()) chk("t2_spacing", gnt_log[i] - gnt_log[i-1], 4);
    end

    // Backpressure with all requesting.
    ready = 1'b0;
    a_in = 32'h07_06_03_00;
    b_in = 32'h07_06_05_A5;
    gq.push_back({4'b0001, 8'h00, 8'hA5});
    rq.push_back({16'h0000, 2'd0});
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (res_valid) break;
    end
    chk("bp_valid", res_valid, 1);
    repeat (5) begin
      tick();
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_res", res, 16'h0000);
      chk("bp_hold_id", res_id, 0);
      chk("bp_hold_gnt", gnt, 0);
    end
    ready = 1'b1;
    req[3:2] = 2'b00;
    exp_op(4'b0010, 8'h03, 8'h05, 16'h000F, 2'd1);
    tick();
    chk("bp_release_valid", res_valid, 0);
    chk("bp_release_gnt", gnt, 0);
    tick();
    chk("bp_next_gnt", gnt, 4'b0010);
    drain("t3");

    // Pointer wrap after a grant to requester 3.
    a_in[31:24] = 8'h10;
    b_in[31:24] = 8'h10;
    exp_op(4'b1000, 8'h10, 8'h10, 16'h0100, 2'd3);
    req = 4'b1000;
    drain("t4a");
    a_in[7:0] = 8'h02;
    b_in[7:0] = 8'h03;
    a_in[23:16] = 8'h07;
    b_in[23:16] = 8'h09;
    exp_op(4'b0001, 8'h02, 8'h03, 16'h0006, 2'd0);
    exp_op(4'b0100, 8'h07, 8'h09, 16'h003F, 2'd2);
    req = 4'b0101;
    drain("t4b");

    // Reset in the cycle after the grant discards the operation.
    a_in[23:16] = 8'h0B;
    b_in[23:16] = 8'h0D;
    gq.push_back({4'b0100, 8'h0B, 8'h0D});
    req = 4'b0100;
    tick();
    chk("t5_gnt", gnt, 4'b0100);
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_mul_a", mul_a, 0);
    chk("t5_rst_mul_b", mul_b, 0);
    chk("t5_rst_res", res, 0);
    chk("t5_rst_res_id", res_id, 0);
    chk("t5_rst_valid", res_valid, 0);
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("t5_no_valid", res_valid, 0);
    end
    a_in[31:24] = 8'h0C;
    b_in[31:24] = 8'h0C;
    exp_op(4'b1000, 8'h0C, 8'h0C, 16'h0090, 2'd3);
    req = 4'b1000;
    drain("t5");

    // SETTLE=1 instance.
    ready1 = 1'b1;
    a1[7:0] = 8'h80;
    b1[7:0] = 8'h02;
    g1q.push_back({4'b0001, 8'h80, 8'h02});
    r1q.push_back({16'h0100, 2'd0});
    req1 = 4'b0001;
    drain("t6a");
    a1[23:16] = 8'hFF;
    b1[23:16] = 8'h02;
    g1q.push_back({4'b0100, 8'hFF, 8'h02});
    r1q.push_back({16'h01FE, 2'd2});
    req1 = 4'b0100;
    drain("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one combinational 8x8 unsigned array multiplier (64 AND cells plus an HA/FA ripple array) between N requesters.
- Grants requesters round-robin and registers the winner's operands onto the multiplier inputs.
- Holds those operands for a fixed number of settle cycles, because the array's ripple path is multi-cycle, then captures the 16-bit product.
- Returns the product with the winner's ID over a valid/ready interface. The multiplier is instantiated outside this block and connects through the mul_* ports.

Parameters:
N, 4, number of requesters (2..8).
IDW, 2, requester ID width; must satisfy 2^IDW >= N.
SETTLE, 2, clock cycles operands are held before the product is sampled (>= 1).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N  per-requester request level; held with operands until its gnt bit pulses.
a_in  input  8*N  requester i operand A at bits [8i+7:8i].
b_in  input  8*N  requester i operand B at bits [8i+7:8i].
gnt  output  N  one-hot, one-cycle grant pulse; operands were captured at the edge that raised it.
mul_a  output  8  registered operand A to the multiplier.
mul_b  output  8  registered operand B to the multiplier.
mul_w  input  16  product from the multiplier.
res  output  16  registered product.
res_id  output  IDW  index of the requester that owns res.
res_valid  output  1  result valid.
res_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rst=1 at a rising edge) sets:
  - state IDLE, gnt=0, mul_a=0, mul_b=0, res=0, res_id=0, res_valid=0;
  - round-robin pointer ptr=0, settle counter cnt=0.
- Reset overrides every other event. Asserting reset mid-operation discards the in-flight operation: no res_valid, no later gnt for it.
- State IDLE:
  - Each cycle, pick the first i with req[i]=1, scanning ptr, ptr+1, ... with wrap at N.
  - At the next edge: mul_a<=a_in[i], mul_b<=b_in[i], gnt<=onehot(i), win<=i, ptr<=(i+1) mod N, cnt<=SETTLE-1, state->WAIT.
  - With no req, stay in IDLE with gnt=0.
  - req is sampled only in IDLE. A request dropped before its grant is simply not served.
- State WAIT:
  - gnt is high only in the first WAIT cycle and returns to 0 at the next edge.
  - If cnt!=0: cnt<=cnt-1 and stay in WAIT.
  - If cnt==0: res<=mul_w, res_id<=win, res_valid<=1, state->DONE.
  - Latency: the first cycle with res_valid=1 is exactly SETTLE cycles after the gnt pulse cycle.
- State DONE:
  - res_valid, res and res_id hold stable until an edge with res_ready=1.
  - At that edge: res_valid<=0, state->IDLE.
  - No grants are issued in DONE, whatever req shows.
  - res_ready is ignored outside DONE.
- Throughput: at most one operation per SETTLE+2 cycles with res_ready tied high.
- mul_a and mul_b keep their last values after completion; they are not cleared.
- res keeps its last value after res_valid falls.
- A requester must drop req, or change it to a new operation, in the cycle after it sees its gnt bit. req still high in the gnt cycle is ignored, because the state is WAIT.
- Arithmetic is unsigned 8x8 -> 16. The block has no overflow case and does no sign handling.
- Pointer wrap: a grant to N-1 sets ptr=0.
- Simultaneous requests from all N from reset are served in order 0,1,...,N-1,0,...

Test Plan:
1. Single request, N=4, SETTLE=2, req=0010, a_in[1]=0x0F, b_in[1]=0x11 -> gnt=0010 for one cycle; mul_a=0x0F, mul_b=0x11; 2 cycles later res_valid=1, res=0x00FF, res_id=1.
2. All four requesting from reset, each with a=0xFF, b=0xFF, res_ready=1; each requester drops req after its gnt -> grants in order 0,1,2,3; each res=0xFE01 with matching res_id; grant spacing is 4 cycles.
3. Backpressure: result res=0x0000 (a=0x00, b=0xA5) with res_ready=0 for 5 cycles while req=1111 -> res_valid, res and res_id stable; gnt stays 0; when res_ready=1 for one cycle, res_valid falls and the next gnt follows 1 cycle later.
4. Pointer wrap: grant to requester 3 completes, then req=0101 -> gnt[0] first, then gnt[2].
5. Reset mid-WAIT: assert rst the cycle after gnt -> next cycle all outputs are at reset values, no res_valid appears, and after release req=1000 is granted (ptr=0 search finds 3).
6. SETTLE=1 with 0x80*0x02 -> res_valid one cycle after the gnt cycle, res=0x0100.
